// File: rtl/adc32_pipe_if.sv
// Operand/result bundle for the two-stage adder: operands in, flagged result out.
// Latency: none (wires only).
// Backpressure: carries in_ready and out_ready between producer, adder and consumer.
interface adc32_pipe_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             co;
   logic             ovf;
   logic             zero;

   // Producer/consumer side: drives operands and result acceptance.
   modport master (
      output in_valid, a, b, sub, out_ready,
      input  in_ready, out_valid, s, co, ovf, zero
   );

   // Adder side: accepts operands, presents results.
   modport slave (
      input  in_valid, a, b, sub, out_ready,
      output in_ready, out_valid, s, co, ovf, zero
   );
endinterface

// File: rtl/adc32_pipe.sv
// Two-stage pipelined add/subtract with carry, signed-overflow and zero flags.
// Latency: result registered on the second clk edge after operands are presented; one op per cycle.
// Backpressure: holds result while out_ready=0; accepts one more op into stage 1, then drops in_ready.
module adc32_pipe #(
   parameter int WIDTH = 32,
   parameter int SPLIT = 16   // low bits resolved in stage 1; 1 <= SPLIT < WIDTH
) (
   input logic          clk,
   input logic          rst,
   adc32_pipe_if.slave  bus
);

   localparam int HW = WIDTH - SPLIT;

   // Everything stage 2 needs: finished low half, the carry into the high half,
   // and the high halves of the conditioned operands.
   typedef struct packed {
      logic [SPLIT-1:0] s_lo;
      logic             c_mid;
      logic [HW-1:0]    a_hi;
      logic [HW-1:0]    bb_hi;
   } s1_t;

   logic             s1_valid;
   s1_t              s1_q;
   s1_t              s1_d;
   logic             out_valid_q;
   logic [WIDTH-1:0] s_q;
   logic             co_q;
   logic             ovf_q;
   logic             zero_q;

   logic             s2_free;
   logic             s1_adv;
   logic             in_xfer;

   // Subtraction is A + ~B + 1: invert B here and feed sub in as carry-in.
   logic [WIDTH-1:0] bb;
   logic [SPLIT-1:0] gen;
   logic [SPLIT-1:0] prop;

   assign bb   = bus.sub ? ~bus.b : bus.b;
   assign gen  = bus.a[SPLIT-1:0] & bb[SPLIT-1:0];
   assign prop = bus.a[SPLIT-1:0] ^ bb[SPLIT-1:0];

   // Stage 1 low half: carries from generate/propagate terms, sum bit = P ^ carry-in.
   always_comb begin : lo_half
      logic cy;
      s1_d  = '0;
      cy    = bus.sub;
      for (int i = 0; i < SPLIT; i++) begin
         s1_d.s_lo[i] = prop[i] ^ cy;
         cy           = gen[i] | (prop[i] & cy);
      end
      s1_d.c_mid = cy;
      s1_d.a_hi  = bus.a[WIDTH-1:SPLIT];
      s1_d.bb_hi = bb[WIDTH-1:SPLIT];
   end

   // Stage 2 high half, resolved from the registered group carry.
   logic [HW:0]      hi_sum;
   logic [WIDTH-1:0] s_d;
   logic             ovf_d;

   assign hi_sum = {1'b0, s1_q.a_hi} + {1'b0, s1_q.bb_hi} + {{HW{1'b0}}, s1_q.c_mid};
   assign s_d    = {hi_sum[HW-1:0], s1_q.s_lo};
   // Signed overflow: operands agree in sign but the result does not.
   assign ovf_d  = (s1_q.a_hi[HW-1] == s1_q.bb_hi[HW-1]) & (hi_sum[HW-1] != s1_q.a_hi[HW-1]);

   // Stall chain: stage 2 frees when empty or being drained; stage 1 accepts when
   // empty or moving forward. out_ready -> in_ready is the only combinational path.
   assign s2_free = !out_valid_q | bus.out_ready;
   assign s1_adv  = s1_valid & s2_free;
   assign in_xfer = bus.in_valid & bus.in_ready;

   assign bus.in_ready  = !s1_valid | s2_free;
   assign bus.out_valid = out_valid_q;
   assign bus.s         = s_q;
   assign bus.co        = co_q;
   assign bus.ovf       = ovf_q;
   assign bus.zero      = zero_q;

   // Stage 1 occupancy: filled by an accepted op, emptied when it moves on.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
      end else if (in_xfer) begin
         s1_valid <= 1'b1;
      end else if (s1_adv) begin
         s1_valid <= 1'b0;
      end
   end

   // Stage 1 data: loaded only on an accepted op, otherwise left alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= '0;
      end else if (in_xfer) begin
         s1_q <= s1_d;
      end
   end

   // Stage 2 result: load on advance, hold while stalled, bubble when drained with nothing behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         s_q         <= '0;
         co_q        <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
      end else if (s1_adv) begin
         out_valid_q <= 1'b1;
         s_q         <= s_d;
         co_q        <= hi_sum[HW];
         ovf_q       <= ovf_d;
         zero_q      <= (s_d == '0);
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_adc32_pipe.sv
// Self-checking bench for adc32_pipe: directed flag cases, backpressure, random stream, mid-run reset.
// Expected results are queued when an op is accepted and popped when a result is accepted.
// Inputs change 1 time unit after posedge; handshakes and results are sampled on negedge.
module tb_adc32_pipe;

   typedef struct packed {
      logic [31:0] s;
      logic        co;
      logic        ovf;
      logic        zero;
   } res_t;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   res_t sb[$];

   always #5 clk = ~clk;

   adc32_pipe_if #(.WIDTH(32)) bus ();

   adc32_pipe #(.WIDTH(32), .SPLIT(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic res_t mk(input logic [31:0] s, input logic co, input logic ovf, input logic zero);
      res_t r;
      r.s    = s;
      r.co   = co;
      r.ovf  = ovf;
      r.zero = zero;
      return r;
   endfunction

   function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
      logic [31:0] bbv;
      logic [32:0] t;
      res_t        r;
      bbv    = sub ? ~b : b;
      t      = {1'b0, a} + {1'b0, bbv} + {32'b0, sub};
      r.s    = t[31:0];
      r.co   = t[32];
      r.ovf  = (a[31] == bbv[31]) && (r.s[31] != a[31]);
      r.zero = (r.s == 32'h0);
      return r;
   endfunction

   function automatic logic [31:0] pick();
      int unsigned k;
      k = $urandom % 8;
      case (k)
         0:       return 32'hFFFF_FFFF;
         1:       return 32'h8000_0000;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'h0000_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one op and hold it until accepted; in_valid is left high for full-rate streaming.
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub, input res_t exp);
      bit acc;
      acc         = 1'b0;
      bus.a       = a;
      bus.b       = b;
      bus.sub     = sub;
      bus.in_valid = 1'b1;
      for (int t = 0; t < 100 && !acc; t++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            sb.push_back(exp);
            acc = 1'b1;
         end
         tick();
      end
      if (!acc) chk("send_timeout", 64'(0), 64'(1));
   endtask

   task automatic drain(input string tag);
      bit done;
      done = 1'b0;
      for (int t = 0; t < 500 && !done; t++) begin
         if (sb.size() == 0 && !bus.out_valid) done = 1'b1;
         else tick();
      end
      chk(tag, 64'(sb.size()), 64'(0));
   endtask

   // Result monitor: each accepted result must match the oldest outstanding expectation.
   always @(negedge clk) begin
      res_t e;
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_result", 64'(1), 64'(0));
         end else begin
            e = sb.pop_front();
            chk("result", 64'({bus.s, bus.co, bus.ovf, bus.zero}), 64'(e));
         end
      end
   end

   initial begin
      int   n;
      res_t held;
      bit   seen;
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rs;

      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.a        = '0;
      bus.b        = '0;
      bus.sub      = 1'b0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      chk("rst_in_ready",  64'(bus.in_ready),  64'(1));
      chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_s",         64'(bus.s),         64'(0));
      chk("rst_co",        64'(bus.co),        64'(0));
      chk("rst_ovf",       64'(bus.ovf),       64'(0));
      chk("rst_zero",      64'(bus.zero),      64'(0));
      rst = 1'b0;
      tick();

      // Carry across the stage boundary, with latency: valid on the second edge, not the first
      send(32'h0000_FFFF, 32'h0000_0001, 1'b0, mk(32'h0001_0000, 1'b0, 1'b0, 1'b0));
      bus.in_valid = 1'b0;
      chk("lat_edge1_out_valid", 64'(bus.out_valid), 64'(0));
      tick();
      chk("lat_edge2_out_valid", 64'(bus.out_valid), 64'(1));
      tick();

      // Subtract, signed overflow and wrap-around
      send(32'd5,          32'd5, 1'b1, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1));
      send(32'd3,          32'd5, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
      send(32'h7FFF_FFFF,  32'd1, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0));
      send(32'hFFFF_FFFF,  32'd1, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1));
      bus.in_valid = 1'b0;
      drain("drain_directed");

      // Backpressure: 5 ops at full rate, consumer stalled 4 cycles from first out_valid
      bus.out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 5; i++) begin
               ra = 32'h1111_1111 * (i + 1);
               rb = 32'h0F0F_0F0F + i;
               rs = i[0];
               send(ra, rb, rs, model(ra, rb, rs));
            end
            bus.in_valid = 1'b0;
         end
         begin
            seen = 1'b0;
            for (int t = 0; t < 50 && !seen; t++) begin
               tick();
               if (bus.out_valid) seen = 1'b1;
            end
            chk("bp_first_out_valid", 64'(seen), 64'(1));
            held = {bus.s, bus.co, bus.ovf, bus.zero};
            for (int k = 0; k < 4; k++) begin
               chk("bp_in_ready_low", 64'(bus.in_ready), 64'(0));
               chk("bp_result_stable", 64'({bus.s, bus.co, bus.ovf, bus.zero}), 64'(held));
               tick();
            end
            bus.out_ready = 1'b1;
         end
      join
      drain("drain_backpressure");

      // Random stream with random in_valid / out_ready
      n = 0;
      for (int t = 0; t < 20000 && n < 1000; t++) begin
         ra            = pick();
         rb            = pick();
         rs            = 1'($urandom % 2);
         bus.a         = ra;
         bus.b         = rb;
         bus.sub       = rs;
         bus.in_valid  = ($urandom % 4) != 0;
         bus.out_ready = ($urandom % 4) != 0;
         @(negedge clk);
         if (bus.in_valid && bus.in_ready) begin
            sb.push_back(model(ra, rb, rs));
            n++;
         end
         tick();
      end
      chk("rand_accepted", 64'(n), 64'(1000));
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      drain("drain_random");

      // Reset with two ops in flight: outputs clear at once, nothing stale emerges afterwards
      bus.out_ready = 1'b0;
      send(32'h1234_5678, 32'h1111_1111, 1'b0, model(32'h1234_5678, 32'h1111_1111, 1'b0));
      send(32'h0000_0001, 32'h0000_0002, 1'b1, model(32'h0000_0001, 32'h0000_0002, 1'b1));
      bus.in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("midrst_in_ready",  64'(bus.in_ready),  64'(1));
      chk("midrst_s",         64'(bus.s),         64'(0));
      chk("midrst_co",        64'(bus.co),        64'(0));
      sb.delete();
      bus.out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("postrst_idle", 64'(bus.out_valid), 64'(0));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
